crypto_chan_engine: RTL

CRYPTO_CHAN_ENGINE -- requirements
Module: crypto_chan_engine

---
 rtl/crypto_pkg.sv | 24 ++
 rtl/crypto_chan.sv | 172 +++++++++++++++++
 rtl/crypto_chan_engine.sv | 64 ++++++
 3 files changed

// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared types and constants for the crypto channel engine
package crypto_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } chan_state_e;

  typedef enum logic {
    DIR_IB,
    DIR_OB
  } dir_e;

  localparam int unsigned RD_LAT = 1;

  localparam logic [31:0] DEF_IB_SRC_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_IB_DST_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_OB_SRC_BASE = 32'h2000_0000;
  localparam logic [31:0] DEF_OB_DST_BASE = 32'h3000_0000;
  localparam logic [31:0] DEF_CH_STRIDE   = 32'h0001_0000;

endpackage

// File: rtl/crypto_chan.sv
// rtl/crypto_chan.sv - one channel: read L words, XOR with key (or bypass), write them back
// RdData must carry the word for the read presented in the same cycle; it is captured at the closing edge.
module crypto_chan
  import crypto_pkg::*;
#(
  parameter int unsigned   CH_IDX      = 0,
  parameter int unsigned   DW          = 128,
  parameter int unsigned   AW          = 32,
  parameter int unsigned   LEN_W       = 5,
  parameter logic [AW-1:0] IB_SRC_BASE = AW'(DEF_IB_SRC_BASE),
  parameter logic [AW-1:0] IB_DST_BASE = AW'(DEF_IB_DST_BASE),
  parameter logic [AW-1:0] OB_SRC_BASE = AW'(DEF_OB_SRC_BASE),
  parameter logic [AW-1:0] OB_DST_BASE = AW'(DEF_OB_DST_BASE),
  parameter logic [AW-1:0] CH_STRIDE   = AW'(DEF_CH_STRIDE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    rd_data_i,
  output logic             rd_en_o,
  output logic [AW-1:0]    rd_addr_o,
  output logic [DW-1:0]    wr_data_o,
  output logic             wr_en_o,
  output logic [AW-1:0]    wr_addr_o,
  input  logic             ib_req_i,
  input  logic             ob_req_i,
  output logic             ib_done_o,
  output logic             ob_done_o,
  input  logic [LEN_W-1:0] len_i,
  input  logic [DW-1:0]    key_i,
  input  logic             bypass_i,
  output logic [15:0]      job_cnt_o
);

  localparam logic [AW-1:0] CH_OFF = AW'(CH_IDX) * CH_STRIDE;

  chan_state_e      state_q, state_d;
  dir_e             dir_q, dir_d;
  dir_e             rr_q, rr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] off_q, off_d;
  logic [DW-1:0]    key_q, key_d;
  logic             byp_q, byp_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             ib_done_q, ib_done_d;
  logic             ob_done_q, ob_done_d;
  logic [15:0]      job_cnt_q, job_cnt_d;

  dir_e             start_dir;
  logic [AW-1:0]    src_start;
  logic [AW-1:0]    dst_base;
  logic             served_req;

  // Contention only matters when both requests are up; rr_q then names the winner.
  assign start_dir  = (ib_req_i && ob_req_i) ? rr_q : (ib_req_i ? DIR_IB : DIR_OB);
  assign src_start  = ((start_dir == DIR_IB) ? IB_SRC_BASE : OB_SRC_BASE) + CH_OFF;
  assign dst_base   = ((dir_q == DIR_IB) ? IB_DST_BASE : OB_DST_BASE) + CH_OFF;
  assign served_req = (dir_q == DIR_IB) ? ib_req_i : ob_req_i;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rr_d      = rr_q;
    len_d     = len_q;
    off_d     = off_q;
    key_d     = key_q;
    byp_d     = byp_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    ib_done_d = ib_done_q;
    ob_done_d = ob_done_q;
    job_cnt_d = job_cnt_q;
    wr_en_d   = rd_en_q;
    wr_addr_d = dst_base + AW'(off_q);
    wr_data_d = byp_q ? rd_data_i : (rd_data_i ^ key_q);

    case (state_q)
      ST_IDLE: begin
        if (ib_req_i || ob_req_i) begin
          dir_d = start_dir;
          rr_d  = (start_dir == DIR_IB) ? DIR_OB : DIR_IB;
          len_d = len_i;
          key_d = key_i;
          byp_d = bypass_i;
          off_d = '0;
          if (len_i == '0) begin
            state_d   = ST_DONE;
            job_cnt_d = job_cnt_q + 16'd1;
            ib_done_d = (start_dir == DIR_IB);
            ob_done_d = (start_dir == DIR_OB);
          end else begin
            state_d   = ST_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = src_start;
          end
        end
      end
      ST_READ: begin
        if (off_q == len_q - LEN_W'(1)) begin
          state_d = ST_DRAIN;
        end else begin
          off_d     = off_q + LEN_W'(1);
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        state_d   = ST_DONE;
        job_cnt_d = job_cnt_q + 16'd1;
        ib_done_d = (dir_q == DIR_IB);
        ob_done_d = (dir_q == DIR_OB);
      end
      ST_DONE: begin
        if (!served_req) begin
          state_d   = ST_IDLE;
          ib_done_d = 1'b0;
          ob_done_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_IB;
      rr_q      <= DIR_IB;
      len_q     <= '0;
      off_q     <= '0;
      key_q     <= '0;
      byp_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ib_done_q <= 1'b0;
      ob_done_q <= 1'b0;
      job_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rr_q      <= rr_d;
      len_q     <= len_d;
      off_q     <= off_d;
      key_q     <= key_d;
      byp_q     <= byp_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ib_done_q <= ib_done_d;
      ob_done_q <= ob_done_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign ib_done_o = ib_done_q;
  assign ob_done_o = ob_done_q;
  assign job_cnt_o = job_cnt_q;

endmodule

// File: rtl/crypto_chan_engine.sv
// rtl/crypto_chan_engine.sv - NUM_CH independent XOR copy channels, each with its own memory ports
module crypto_chan_engine
  import crypto_pkg::*;
#(
  parameter int unsigned   NUM_CH      = 8,
  parameter int unsigned   DW          = 128,
  parameter int unsigned   AW          = 32,
  parameter int unsigned   LEN_W       = 5,
  parameter logic [AW-1:0] IB_SRC_BASE = AW'(DEF_IB_SRC_BASE),
  parameter logic [AW-1:0] IB_DST_BASE = AW'(DEF_IB_DST_BASE),
  parameter logic [AW-1:0] OB_SRC_BASE = AW'(DEF_OB_SRC_BASE),
  parameter logic [AW-1:0] OB_DST_BASE = AW'(DEF_OB_DST_BASE),
  parameter logic [AW-1:0] CH_STRIDE   = AW'(DEF_CH_STRIDE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0][DW-1:0]    RdData,
  output logic [NUM_CH-1:0]            RdEn,
  output logic [NUM_CH-1:0][AW-1:0]    RdAddr,
  output logic [NUM_CH-1:0][DW-1:0]    WrData,
  output logic [NUM_CH-1:0]            WrEn,
  output logic [NUM_CH-1:0][AW-1:0]    WrAddr,
  input  logic [NUM_CH-1:0]            IbIPSECValid,
  output logic [NUM_CH-1:0]            IbPCIeValid,
  input  logic [NUM_CH-1:0]            ObIPSECValid,
  output logic [NUM_CH-1:0]            ObPCIeValid,
  input  logic [NUM_CH-1:0][LEN_W-1:0] Len,
  input  logic [NUM_CH-1:0][DW-1:0]    Key,
  input  logic [NUM_CH-1:0]            Bypass,
  output logic [NUM_CH-1:0][15:0]      JobCnt
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    crypto_chan #(
      .CH_IDX      (c),
      .DW          (DW),
      .AW          (AW),
      .LEN_W       (LEN_W),
      .IB_SRC_BASE (IB_SRC_BASE),
      .IB_DST_BASE (IB_DST_BASE),
      .OB_SRC_BASE (OB_SRC_BASE),
      .OB_DST_BASE (OB_DST_BASE),
      .CH_STRIDE   (CH_STRIDE)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .rd_data_i (RdData[c]),
      .rd_en_o   (RdEn[c]),
      .rd_addr_o (RdAddr[c]),
      .wr_data_o (WrData[c]),
      .wr_en_o   (WrEn[c]),
      .wr_addr_o (WrAddr[c]),
      .ib_req_i  (IbIPSECValid[c]),
      .ob_req_i  (ObIPSECValid[c]),
      .ib_done_o (IbPCIeValid[c]),
      .ob_done_o (ObPCIeValid[c]),
      .len_i     (Len[c]),
      .key_i     (Key[c]),
      .bypass_i  (Bypass[c]),
      .job_cnt_o (JobCnt[c])
    );
  end

endmodule
